mem_port_scheduler: RTL and testbench

MEM_PORT_SCHEDULER -- requirements
Module: mem_port_scheduler

---
 rtl/mem_port_scheduler.sv | 160 ++++++++++++++++
 tb/tb_mem_port_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_scheduler.sv
// Data-memory write-port scheduler: CPU has priority, two UART hold buffers drain round-robin.
// Optional starvation guard enabled by defining MEM_SCHED_STARVE_GUARD_EN.
module mem_port_scheduler #(
   parameter int unsigned DATA_MEM_ADDR_SIZE = 10,
   parameter int unsigned DATA_W             = 32,
   parameter int unsigned STARVE_LIMIT       = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cpuReq,
   input  logic                          cpuWe,
   input  logic [DATA_MEM_ADDR_SIZE-1:0] cpuAddr,
   input  logic [DATA_W-1:0]             cpuWData,
   input  logic                          u0Req,
   input  logic [DATA_MEM_ADDR_SIZE-1:0] u0Addr,
   input  logic [DATA_W-1:0]             u0Data,
   input  logic                          u1Req,
   input  logic [DATA_MEM_ADDR_SIZE-1:0] u1Addr,
   input  logic [DATA_W-1:0]             u1Data,
   output logic                          u0Ack,
   output logic                          u1Ack,
   output logic                          memWe,
   output logic [DATA_MEM_ADDR_SIZE-1:0] memAddr,
   output logic [DATA_W-1:0]             memWData,
   output logic                          cpuStall,
   output logic [1:0]                    pending
);

   localparam int unsigned AW = DATA_MEM_ADDR_SIZE;
   localparam int unsigned DW = DATA_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PEND  = 2'd1,
      DRAIN = 2'd2
   } schedState_t;

   schedState_t     state;
   schedState_t     stateNext;
   logic [1:0]      bufValid;
   logic [AW-1:0]   bufAddr [2];
   logic [DW-1:0]   bufData [2];
   logic            rrPtr;
   logic [1:0]      ackQ;
   logic [1:0]      uReq;
   logic [1:0]      drain;
   logic [1:0]      capture;
   logic [1:0]      validNext;
   logic            cpuOwn;
   logic            uartOwn;
   logic            sel;
   logic            stallC;

   assign uReq = {u1Req, u0Req};

`ifdef MEM_SCHED_STARVE_GUARD_EN
   localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0] starveCnt;

   // Counts CPU-owned cycles while a UART buffer waits; at the limit the CPU yields once.
   assign stallC = !rst && cpuReq && (state != IDLE) && (starveCnt == CW'(STARVE_LIMIT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starveCnt <= '0;
      end else if (cpuReq && (state != IDLE) && !stallC) begin
         starveCnt <= starveCnt + CW'(1);
      end else begin
         starveCnt <= '0;
      end
   end
`else
   assign stallC = 1'b0;
`endif

   // Owner selection, memory-port mux, capture decisions and FSM next state.
   always_comb begin
      cpuOwn    = 1'b0;
      uartOwn   = 1'b0;
      sel       = 1'b0;
      drain     = 2'b00;
      capture   = 2'b00;
      validNext = bufValid;
      stateNext = state;
      memWe     = 1'b0;
      memAddr   = '0;
      memWData  = '0;

      if (bufValid == 2'b11) begin
         sel = rrPtr;
      end else begin
         sel = bufValid[1];
      end

      if (!rst) begin
         cpuOwn  = cpuReq && !stallC;
         uartOwn = !cpuOwn && (state != IDLE);
      end

      if (cpuOwn) begin
         memWe    = cpuWe;
         memAddr  = cpuAddr;
         memWData = cpuWData;
      end else if (uartOwn) begin
         memWe      = 1'b1;
         memAddr    = bufAddr[sel];
         memWData   = bufData[sel];
         drain[sel] = 1'b1;
      end

      for (int i = 0; i < 2; i++) begin
         capture[i]   = uReq[i] && (!bufValid[i] || drain[i]);
         validNext[i] = (bufValid[i] && !drain[i]) || capture[i];
      end

      if (validNext == 2'b00) begin
         stateNext = IDLE;
      end else if (uartOwn) begin
         stateNext = DRAIN;
      end else begin
         stateNext = PEND;
      end
   end

   // Control state; reset discards any buffered UART data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         bufValid <= 2'b00;
         rrPtr    <= 1'b0;
         ackQ     <= 2'b00;
      end else begin
         state    <= stateNext;
         bufValid <= validNext;
         ackQ     <= capture;
         if (uartOwn) begin
            rrPtr <= ~sel;
         end
      end
   end

   // Hold-buffer payload; qualified by bufValid so it needs no reset.
   always_ff @(posedge clk) begin
      if (capture[0]) begin
         bufAddr[0] <= u0Addr;
         bufData[0] <= u0Data;
      end
      if (capture[1]) begin
         bufAddr[1] <= u1Addr;
         bufData[1] <= u1Data;
      end
   end

   assign u0Ack    = ackQ[0];
   assign u1Ack    = ackQ[1];
   assign pending  = bufValid;
   assign cpuStall = stallC;

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed self-checking bench for mem_port_scheduler (default or MEM_SCHED_STARVE_GUARD_EN build).
module tb_mem_port_scheduler;

   localparam int unsigned AW = 10;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpuReq;
   logic          cpuWe;
   logic [AW-1:0] cpuAddr;
   logic [DW-1:0] cpuWData;
   logic          u0Req;
   logic [AW-1:0] u0Addr;
   logic [DW-1:0] u0Data;
   logic          u1Req;
   logic [AW-1:0] u1Addr;
   logic [DW-1:0] u1Data;
   logic          u0Ack;
   logic          u1Ack;
   logic          memWe;
   logic [AW-1:0] memAddr;
   logic [DW-1:0] memWData;
   logic          cpuStall;
   logic [1:0]    pending;

   int passCount = 0;
   int totalCount = 0;

   mem_port_scheduler #(
      .DATA_MEM_ADDR_SIZE(AW),
      .DATA_W(DW),
      .STARVE_LIMIT(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cpuReq(cpuReq),
      .cpuWe(cpuWe),
      .cpuAddr(cpuAddr),
      .cpuWData(cpuWData),
      .u0Req(u0Req),
      .u0Addr(u0Addr),
      .u0Data(u0Data),
      .u1Req(u1Req),
      .u1Addr(u1Addr),
      .u1Data(u1Data),
      .u0Ack(u0Ack),
      .u1Ack(u1Ack),
      .memWe(memWe),
      .memAddr(memAddr),
      .memWData(memWData),
      .cpuStall(cpuStall),
      .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      totalCount = totalCount + 1;
      assert (obs === exp) passCount = passCount + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic expStall;
      rst = 1'b1; cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 10'h3FF; cpuWData = 32'hDEAD;
      u0Req = 1'b1; u0Addr = 10'h03C; u0Data = 32'h1;
      u1Req = 1'b0; u1Addr = '0; u1Data = '0;

      // Reset state with requests present
      tick(); tick();
      @(negedge clk);
      check("rst_memWe", 64'(memWe), 64'd0);
      check("rst_pending", 64'(pending), 64'd0);
      check("rst_u0Ack", 64'(u0Ack), 64'd0);
      check("rst_cpuStall", 64'(cpuStall), 64'd0);
      tick();
      rst = 1'b0; u0Req = 1'b0; cpuReq = 1'b0; cpuWe = 1'b0;
      @(negedge clk);
      check("rel_u0Ack", 64'(u0Ack), 64'd0);
      check("rel_pending", 64'(pending), 64'd0);

      // Single UART0 write, minimum latency
      tick();
      u0Req = 1'b1; u0Addr = 10'h104; u0Data = 32'hA5;
      tick();
      u0Req = 1'b0;
      @(negedge clk);
      check("a_u0Ack", 64'(u0Ack), 64'd1);
      check("a_memWe", 64'(memWe), 64'd1);
      check("a_memAddr", 64'(memAddr), 64'h104);
      check("a_memWData", 64'(memWData), 64'hA5);
      check("a_pending", 64'(pending), 64'b01);
      tick();
      @(negedge clk);
      check("a_pendingAfter", 64'(pending), 64'b00);
      check("a_memWeAfter", 64'(memWe), 64'd0);
      check("a_u0AckAfter", 64'(u0Ack), 64'd0);

      // Pair with rrPtr pointing at UART1 -> UART1 first
      tick();
      u0Req = 1'b1; u0Addr = 10'h110; u0Data = 32'h11;
      u1Req = 1'b1; u1Addr = 10'h210; u1Data = 32'h22;
      tick();
      u0Req = 1'b0; u1Req = 1'b0;
      @(negedge clk);
      check("b_u0Ack", 64'(u0Ack), 64'd1);
      check("b_u1Ack", 64'(u1Ack), 64'd1);
      check("b_first_addr", 64'(memAddr), 64'h210);
      check("b_first_data", 64'(memWData), 64'h22);
      check("b_pending11", 64'(pending), 64'b11);
      tick();
      @(negedge clk);
      check("b_second_addr", 64'(memAddr), 64'h110);
      check("b_second_data", 64'(memWData), 64'h11);
      check("b_pending01", 64'(pending), 64'b01);
      tick();
      @(negedge clk);
      check("b_pendingAfter", 64'(pending), 64'b00);

      // Reset, then a pair -> UART0 first
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      u0Req = 1'b1; u0Addr = 10'h120; u0Data = 32'h33;
      u1Req = 1'b1; u1Addr = 10'h220; u1Data = 32'h44;
      tick();
      u0Req = 1'b0; u1Req = 1'b0;
      @(negedge clk);
      check("c_first_addr", 64'(memAddr), 64'h120);
      check("c_first_data", 64'(memWData), 64'h33);
      check("c_pending11", 64'(pending), 64'b11);
      tick();
      @(negedge clk);
      check("c_second_addr", 64'(memAddr), 64'h220);
      check("c_pending10", 64'(pending), 64'b10);
      tick();
      @(negedge clk);
      check("c_pendingAfter", 64'(pending), 64'b00);

      // CPU store stream for 5 cycles while UART1 waits
      tick();
      cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 10'h020; cpuWData = 32'hC0;
      u1Req = 1'b1; u1Addr = 10'h300; u1Data = 32'hBEEF;
      @(negedge clk);
      check("d_cpuAddr0", 64'(memAddr), 64'h020);
      tick();
      u1Req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cpuAddr = AW'(32'h21 + i);
         cpuWData = DW'(32'hC1 + i);
         @(negedge clk);
         check("d_cpuWe", 64'(memWe), 64'd1);
         check("d_cpuAddr", 64'(memAddr), 64'(32'h21 + i));
         check("d_cpuData", 64'(memWData), 64'(32'hC1 + i));
         check("d_pending10", 64'(pending), 64'b10);
         check("d_u1Ack", 64'(u1Ack), 64'(i == 0));
         tick();
      end
      cpuReq = 1'b0; cpuWe = 1'b0;
      @(negedge clk);
      check("d_drainWe", 64'(memWe), 64'd1);
      check("d_drainAddr", 64'(memAddr), 64'h300);
      check("d_drainData", 64'(memWData), 64'hBEEF);
      tick();
      @(negedge clk);
      check("d_pendingAfter", 64'(pending), 64'b00);

      // UART0 buffer full, request held while CPU busy
      tick();
      cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 10'h040; cpuWData = 32'h40;
      u0Req = 1'b1; u0Addr = 10'h140; u0Data = 32'h1111;
      tick();
      u0Addr = 10'h141; u0Data = 32'h2222;
      @(negedge clk);
      check("e_fillAck", 64'(u0Ack), 64'd1);
      check("e_pending01", 64'(pending), 64'b01);
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         check("e_noAck", 64'(u0Ack), 64'd0);
         check("e_heldPending", 64'(pending), 64'b01);
         check("e_cpuAddr", 64'(memAddr), 64'h040);
      end
      tick();
      cpuReq = 1'b0; cpuWe = 1'b0;
      @(negedge clk);
      check("e_drainWe", 64'(memWe), 64'd1);
      check("e_drainAddr", 64'(memAddr), 64'h140);
      check("e_drainData", 64'(memWData), 64'h1111);
      check("e_drainAck", 64'(u0Ack), 64'd0);
      tick();
      u0Req = 1'b0;
      @(negedge clk);
      check("e_newAck", 64'(u0Ack), 64'd1);
      check("e_newAddr", 64'(memAddr), 64'h141);
      check("e_newData", 64'(memWData), 64'h2222);
      tick();
      @(negedge clk);
      check("e_pendingAfter", 64'(pending), 64'b00);
      check("e_ackAfter", 64'(u0Ack), 64'd0);

      // CPU reads held with UART0 valid: starvation behaviour
      tick();
      cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 10'h050; cpuWData = 32'h0;
      u0Req = 1'b1; u0Addr = 10'h150; u0Data = 32'h5555;
      tick();
      u0Req = 1'b0;
      for (int i = 1; i <= 9; i++) begin
`ifdef MEM_SCHED_STARVE_GUARD_EN
         expStall = (i == 9);
`else
         expStall = 1'b0;
`endif
         @(negedge clk);
         check("f_cpuStall", 64'(cpuStall), 64'(expStall));
         check("f_memWe", 64'(memWe), 64'(expStall));
         check("f_memAddr", 64'(memAddr), expStall ? 64'h150 : 64'h050);
         tick();
      end
`ifdef MEM_SCHED_STARVE_GUARD_EN
      @(negedge clk);
      check("f_pendingAfterStall", 64'(pending), 64'b00);
      check("f_stallOneCycle", 64'(cpuStall), 64'd0);
      tick();
      cpuReq = 1'b0;
`else
      cpuReq = 1'b0;
      @(negedge clk);
      check("f_drainAddr", 64'(memAddr), 64'h150);
      check("f_drainData", 64'(memWData), 64'h5555);
      tick();
      @(negedge clk);
      check("f_pendingAfter", 64'(pending), 64'b00);
      tick();
`endif

      // Reset while both buffers hold data
      cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 10'h060; cpuWData = 32'h60;
      u0Req = 1'b1; u0Addr = 10'h160; u0Data = 32'h6;
      u1Req = 1'b1; u1Addr = 10'h260; u1Data = 32'h7;
      tick();
      u0Req = 1'b0; u1Req = 1'b0;
      @(negedge clk);
      check("g_pending11", 64'(pending), 64'b11);
      #1;
      rst = 1'b1;
      #1;
      check("g_rstPending", 64'(pending), 64'b00);
      check("g_rstMemWe", 64'(memWe), 64'd0);
      check("g_rstAcks", 64'({u1Ack, u0Ack}), 64'b00);
      tick();
      tick();
      rst = 1'b0; cpuReq = 1'b0; cpuWe = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("g_noWrite", 64'(memWe), 64'd0);
         check("g_pending00", 64'(pending), 64'b00);
         tick();
      end

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
